// File: rtl/clk_div_pkg.sv
// Shared constants and channel state encoding for the multi-channel clock divider.
package clk_div_pkg;

    localparam int          CNT_W_DEF    = 26;
    localparam int unsigned DEF_HALF_DEF = 50_000_000;
    localparam int unsigned SPEEDUP_HALF = 5;

    typedef enum logic [1:0] {
        OFF,
        IDLE,
        RUN
    } chan_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/shadow divisor pair and tick strobe.
// CLK_DIV_SIM_SPEEDUP_EN clamps the boundary compare to SPEEDUP_HALF for simulation.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          CNT_W    = CNT_W_DEF,
    parameter int unsigned DEF_HALF = DEF_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [CNT_W-1:0] val,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_HALF);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] half_eff;
    chan_state_t      state;
    logic             boundary;
    logic             apply;

    always_comb begin
        if (active == '0) begin
            state = OFF;
        end else if (en) begin
            state = RUN;
        end else begin
            state = IDLE;
        end
    end

`ifdef CLK_DIV_SIM_SPEEDUP_EN
    assign half_eff = (active > CNT_W'(SPEEDUP_HALF)) ? CNT_W'(SPEEDUP_HALF) : active;
`else
    assign half_eff = active;
`endif

    // active != 0 in RUN, so half_eff - 1 never underflows where it matters.
    assign boundary = (state == RUN) && (cnt >= half_eff - CNT_W'(1));
    assign apply    = pending && ((state != RUN) || boundary);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            active  <= DEF_VAL;
            shadow  <= DEF_VAL;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (we) begin
                shadow <= val;
            end
            // A write on the apply edge keeps pending set for the newer value.
            if (apply) begin
                active <= shadow;
            end
            if (we) begin
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (boundary) begin
                        cnt <= '0;
                        if (apply && (shadow == '0)) begin
                            clk_out <= 1'b0;
                        end else begin
                            clk_out <= ~clk_out;
                            tick    <= ~clk_out;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt     <= '0;
                    clk_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: decodes the divisor write port onto NCH channels.
// Optional macro CLK_DIV_SIM_SPEEDUP_EN shortens every half-period to at most 5 cycles.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int          NCH      = 2,
    parameter int          CNT_W    = CNT_W_DEF,
    parameter int unsigned DEF_HALF = DEF_HALF_DEF,
    localparam int         CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic             div_we,
    input  logic [CH_W-1:0]  div_ch,
    input  logic [CNT_W-1:0] div_val,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pending
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        // Selects at or above NCH match no channel and are dropped.
        localparam logic [CH_W-1:0] IDX = CH_W'(i);

        logic we_ch;
        assign we_ch = div_we && (div_ch == IDX);

        clk_div_chan #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .we      (we_ch),
            .val     (div_val),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: cycle table for run/reprogram/collision plus corner sequences.
module tb_clk_div_multi;

    localparam int NCH = 3;
`ifdef CLK_DIV_SIM_SPEEDUP_EN
    localparam int          CW = 26;
    localparam int unsigned DH = 50_000_000;
`else
    localparam int          CW = 8;
    localparam int unsigned DH = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    en;
    logic          div_we;
    logic [1:0]    div_ch;
    logic [CW-1:0] div_val;
    logic [2:0]    clk_out;
    logic [2:0]    tick;
    logic [2:0]    pending;

    int checks = 0;
    int errors = 0;

    clk_div_multi #(
        .NCH      (NCH),
        .CNT_W    (CW),
        .DEF_HALF (DH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_we  (div_we),
        .div_ch  (div_ch),
        .div_val (div_val),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    en;
        logic          we;
        logic [1:0]    ch;
        logic [CW-1:0] val;
        logic [2:0]    co;
        logic [2:0]    tk;
        logic [2:0]    pd;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic [2:0] e, input logic w, input logic [1:0] c,
                       input logic [CW-1:0] v, input logic [2:0] co, input logic [2:0] tk,
                       input logic [2:0] pd);
        vec_t r;
        r.en = e; r.we = w; r.ch = c; r.val = v; r.co = co; r.tk = tk; r.pd = pd;
        for (int i = 0; i < n; i++) tbl.push_back(r);
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 3'b000; div_we = 1'b0; div_ch = 2'd0; div_val = '0;
        step();
        step();
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_pending", 32'(pending), 0);
        rst = 1'b1;
    endtask

`ifdef CLK_DIV_SIM_SPEEDUP_EN
    task automatic run_speedup();
        en = 3'b001;
        repeat (4) step();
        chk("sp_c4", 32'(clk_out[0]), 0);
        step();
        chk("sp_c5", 32'(clk_out[0]), 1);
        chk("sp_c5_tick", 32'(tick[0]), 1);
        repeat (4) step();
        chk("sp_c9", 32'(clk_out[0]), 1);
        step();
        chk("sp_c10", 32'(clk_out[0]), 0);
        repeat (5) step();
        chk("sp_c15", 32'(clk_out[0]), 1);
        chk("sp_c15_tick", 32'(tick[0]), 1);
        div_we = 1'b1; div_ch = 2'd0; div_val = 3;
        step();
        div_we = 1'b0;
        chk("sp_wr_pend", 32'(pending[0]), 1);
        repeat (4) step();
        chk("sp_c20", 32'(clk_out[0]), 0);
        chk("sp_c20_pend", 32'(pending[0]), 0);
        repeat (3) step();
        chk("sp_c23", 32'(clk_out[0]), 1);
        chk("sp_c23_tick", 32'(tick[0]), 1);
        repeat (3) step();
        chk("sp_c26", 32'(clk_out[0]), 0);
        repeat (3) step();
        chk("sp_c29", 32'(clk_out[0]), 1);
    endtask
`else
    task automatic fill_table();
        // Both live channels run at the default half of 4; ch2 stays disabled.
        add(3, 3'b011, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b011, 3'b011, 3'b000);
        add(3, 3'b011, 0, 0, 0, 3'b011, 3'b000, 3'b000);
        add(4, 3'b011, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b011, 3'b011, 3'b000);
        add(3, 3'b011, 0, 0, 0, 3'b011, 3'b000, 3'b000);
        add(4, 3'b011, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b011, 3'b011, 3'b000);
        // Reprogram ch0 to 2 mid-half; applies at cycle 24.
        add(1, 3'b011, 1, 0, 2, 3'b011, 3'b000, 3'b001);
        add(2, 3'b011, 0, 0, 0, 3'b011, 3'b000, 3'b001);
        add(2, 3'b011, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b001, 3'b001, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b001, 3'b000, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b010, 3'b010, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b010, 3'b000, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b011, 3'b001, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b011, 3'b000, 3'b000);
        add(2, 3'b011, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b001, 3'b001, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b001, 3'b000, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b010, 3'b010, 3'b000);
        // Write 3, then 6 on the boundary edge: 3 applies at 38, 6 at 41.
        add(1, 3'b011, 1, 0, 3, 3'b010, 3'b000, 3'b001);
        add(1, 3'b011, 1, 0, 6, 3'b011, 3'b001, 3'b001);
        add(1, 3'b011, 0, 0, 0, 3'b011, 3'b000, 3'b001);
        add(1, 3'b011, 0, 0, 0, 3'b001, 3'b000, 3'b001);
        add(3, 3'b011, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b010, 3'b010, 3'b000);
        add(2, 3'b011, 0, 0, 0, 3'b010, 3'b000, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b011, 3'b001, 3'b000);
        add(4, 3'b011, 0, 0, 0, 3'b001, 3'b000, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b011, 3'b010, 3'b000);
        add(1, 3'b011, 0, 0, 0, 3'b010, 3'b000, 3'b000);
    endtask

    task automatic run_main();
        int t0, c0, t1, hi;
        fill_table();
        foreach (tbl[i]) begin
            en = tbl[i].en; div_we = tbl[i].we; div_ch = tbl[i].ch; div_val = tbl[i].val;
            step();
            chk($sformatf("tbl%0d_clk_out", i + 1), 32'(clk_out), 32'(tbl[i].co));
            chk($sformatf("tbl%0d_tick", i + 1), 32'(tick), 32'(tbl[i].tk));
            chk($sformatf("tbl%0d_pending", i + 1), 32'(pending), 32'(tbl[i].pd));
        end
        div_we = 1'b0;

        // Async reset mid-run with a pending write on ch1.
        div_we = 1'b1; div_ch = 2'd1; div_val = 5;
        step();
        div_we = 1'b0;
        chk("pend_before_rst", 32'(pending), 32'h2);
        #3 rst = 1'b0;
        #1;
        chk("arst_clk_out", 32'(clk_out), 0);
        chk("arst_tick", 32'(tick), 0);
        chk("arst_pending", 32'(pending), 0);
        step();
        rst = 1'b1;
        repeat (3) step();
        chk("post_rst_c3", 32'(clk_out), 0);
        step();
        chk("post_rst_c4", 32'(clk_out), 32'h3);
        chk("post_rst_c4_tick", 32'(tick), 32'h3);

        // Divisor 1: clk/2 with a tick every other cycle.
        div_we = 1'b1; div_ch = 2'd0; div_val = 1;
        step();
        div_we = 1'b0;
        chk("w1_pend", 32'(pending), 32'h1);
        repeat (3) step();
        chk("w1_applied_pend", 32'(pending), 0);
        chk("w1_applied_clk", 32'(clk_out[0]), 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("div1_clk_%0d", k), 32'(clk_out[0]), 32'(k % 2));
            chk($sformatf("div1_tick_%0d", k), 32'(tick[0]), 32'(k % 2));
        end

        // Divisor 0: one last toggle, then stopped at the next boundary.
        div_we = 1'b1; div_ch = 2'd0; div_val = 0;
        step();
        div_we = 1'b0;
        chk("w0_clk", 32'(clk_out[0]), 1);
        chk("w0_pend", 32'(pending[0]), 1);
        step();
        chk("w0_stop_clk", 32'(clk_out[0]), 0);
        chk("w0_stop_pend", 32'(pending), 0);
        t0 = 0; c0 = 0; t1 = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            t0 += int'(tick[0]);
            c0 += int'(clk_out[0]);
            t1 += int'(tick[1]);
        end
        chk("off_tick0", 32'(t0), 0);
        chk("off_clk0", 32'(c0), 0);
        chk("off_ch1_ticks", 32'(t1), 2);

        // Out-of-range select, then restart ch0 from OFF.
        div_we = 1'b1; div_ch = 2'd3; div_val = 7;
        step();
        div_we = 1'b0;
        chk("badsel_pend", 32'(pending), 0);
        chk("badsel_clk0", 32'(clk_out[0]), 0);
        div_we = 1'b1; div_ch = 2'd0; div_val = 2;
        step();
        div_we = 1'b0;
        chk("restart_pend", 32'(pending), 32'h1);
        step();
        chk("restart_applied", 32'(pending), 0);
        step();
        chk("restart_c1", 32'(clk_out[0]), 0);
        step();
        chk("restart_c2", 32'(clk_out[0]), 1);
        chk("restart_c2_tick", 32'(tick[0]), 1);

        // Drop en[1] mid high phase, then re-enable.
        for (int k = 0; k < 20 && !tick[1]; k++) step();
        chk("en_wait_tick1", 32'(tick[1]), 1);
        step();
        chk("en_mid_high", 32'(clk_out[1]), 1);
        en = 3'b001;
        step();
        chk("en_drop_clk1", 32'(clk_out[1]), 0);
        chk("en_drop_tick1", 32'(tick[1]), 0);
        hi = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            hi += int'(clk_out[1]) + int'(tick[1]);
        end
        chk("idle_quiet1", 32'(hi), 0);
        en = 3'b011;
        repeat (3) step();
        chk("en_rise_c3", 32'(clk_out[1]), 0);
        step();
        chk("en_rise_c4", 32'(clk_out[1]), 1);
        chk("en_rise_c4_tick", 32'(tick[1]), 1);
    endtask
`endif

    initial begin
        do_reset();
`ifdef CLK_DIV_SIM_SPEEDUP_EN
        run_speedup();
`else
        en = 3'b011;
        run_main();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
